// File: rtl/cmsdk_ahb_pkg.sv
// ---------------------------------------------------------------------------
// cmsdk_ahb_pkg
// Shared AHB encodings for the two-master arbiter slice.
//   TRANS_*  : HTRANS transfer-type codes
//   RESP_*   : HRESP response codes
//   trans_pending() : true when a transfer type asks for an address phase
// ---------------------------------------------------------------------------
package cmsdk_ahb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // NONSEQ and SEQ are the only types that carry a real transfer
  function automatic logic trans_pending(input logic [1:0] trans);
    return (trans != TRANS_IDLE) && (trans != TRANS_BUSY);
  endfunction

endpackage

// File: rtl/cmsdk_ahb_master_arbiter64_if.sv
// ---------------------------------------------------------------------------
// cmsdk_ahb_master_arbiter64_if
// One 64-bit AHB link (request side plus response side).
//   modport master : view of an AHB master (drives request, receives response)
//   modport slave  : view of an AHB slave  (receives request, drives response)
// The arbiter takes two links as "slave" (one per master) and one as
// "master" (towards the shared slave).
// ---------------------------------------------------------------------------
interface cmsdk_ahb_master_arbiter64_if;

  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        EXREQ;
  logic [1:0]  MEMATTR;
  logic        HMASTLOCK;
  logic [63:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic        EXRESP;
  logic [63:0] HRDATA;

  modport master (
    output HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, EXREQ, MEMATTR,
           HMASTLOCK, HWDATA,
    input  HREADY, HRESP, EXRESP, HRDATA
  );

  modport slave (
    input  HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, EXREQ, MEMATTR,
           HMASTLOCK, HWDATA,
    output HREADY, HRESP, EXRESP, HRDATA
  );

endinterface

// File: rtl/cmsdk_ahb_arb_respbuf.sv
// ---------------------------------------------------------------------------
// cmsdk_ahb_arb_respbuf
// Per-master response buffer. When a master loses the address bus in the
// same cycle its data phase completes, the read data is parked here and the
// master is held off until it owns the bus again, at which point the parked
// data is delivered.
//   clk, rst   : clock, synchronous active-high reset
//   selected   : this master is the combinational bus selection
//   data_mine  : the slave's current data phase belongs to this master
//   hready     : slave HREADY
//   pending    : this master is presenting NONSEQ/SEQ
//   hrdata     : slave HRDATA
//   hready_m   : HREADY returned to the master
//   hrdata_m   : HRDATA returned to the master
// ---------------------------------------------------------------------------
module cmsdk_ahb_arb_respbuf (
  input  logic        clk,
  input  logic        rst,
  input  logic        selected,
  input  logic        data_mine,
  input  logic        hready,
  input  logic        pending,
  input  logic [63:0] hrdata,
  output logic        hready_m,
  output logic [63:0] hrdata_m
);

  logic        bufv;
  logic [63:0] buf_data;
  logic        lose;

  // data phase finishing on the slave while the address bus moves away
  assign lose = data_mine && !selected && hready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bufv     <= 1'b0;
      buf_data <= '0;
    end else if (lose) begin
      bufv     <= 1'b1;
      buf_data <= hrdata;
    end else if (selected && hready) begin
      bufv     <= 1'b0;
    end
  end

  // a parked completion hides the slave's HREADY until the master is back
  always_comb begin
    hready_m = 1'b1;
    if (rst)
      hready_m = 1'b1;
    else if (lose)
      hready_m = 1'b0;
    else if (selected)
      hready_m = hready;
    else
      hready_m = !(pending || bufv);
  end

  assign hrdata_m = bufv ? buf_data : hrdata;

endmodule

// File: rtl/cmsdk_ahb_master_arbiter64.sv
// ---------------------------------------------------------------------------
// cmsdk_ahb_master_arbiter64
// Two-master to one-slave AHB arbiter, 64-bit data, zero added latency.
// Round-robin at transfer granularity; SEQ/BUSY beats and locked sequences
// keep the bus, and an ERROR response blocks hand-over.
//   InitOwner : address-phase owner after reset (0 = M0, 1 = M1)
//   HCLK      : clock
//   HRESET    : synchronous active-high reset
//   m0, m1    : master links (arbiter acts as their slave)
//   s         : link to the shared slave (arbiter acts as its master)
// ---------------------------------------------------------------------------
module cmsdk_ahb_master_arbiter64
  import cmsdk_ahb_pkg::*;
#(
  parameter bit InitOwner = 1'b0
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  cmsdk_ahb_master_arbiter64_if.slave   m0,
  cmsdk_ahb_master_arbiter64_if.slave   m1,
  cmsdk_ahb_master_arbiter64_if.master  s
);

  logic       addr_owner;
  logic       data_owner;
  logic       data_act;
  logic [1:0] own_trans;
  logic [1:0] oth_trans;
  logic       own_lock;
  logic       grant_other;
  logic       sel;
  logic [1:0] sel_trans;

  // hand-over only at a transfer boundary of the owner, never mid-burst,
  // under lock, during a wait state or inside an ERROR response
  always_comb begin
    own_trans   = addr_owner ? m1.HTRANS : m0.HTRANS;
    oth_trans   = addr_owner ? m0.HTRANS : m1.HTRANS;
    own_lock    = addr_owner ? m1.HMASTLOCK : m0.HMASTLOCK;
    grant_other = s.HREADY && (s.HRESP != RESP_ERROR) && !own_lock &&
                  ((own_trans == TRANS_IDLE) || (own_trans == TRANS_NONSEQ)) &&
                  (oth_trans == TRANS_NONSEQ);
    if (HRESET)
      sel = InitOwner;
    else
      sel = grant_other ? ~addr_owner : addr_owner;
  end

  assign sel_trans   = sel ? m1.HTRANS : m0.HTRANS;

  assign s.HTRANS    = sel_trans;
  assign s.HADDR     = sel ? m1.HADDR     : m0.HADDR;
  assign s.HWRITE    = sel ? m1.HWRITE    : m0.HWRITE;
  assign s.HSIZE     = sel ? m1.HSIZE     : m0.HSIZE;
  assign s.HBURST    = sel ? m1.HBURST    : m0.HBURST;
  assign s.HPROT     = sel ? m1.HPROT     : m0.HPROT;
  assign s.EXREQ     = sel ? m1.EXREQ     : m0.EXREQ;
  assign s.MEMATTR   = sel ? m1.MEMATTR   : m0.MEMATTR;
  assign s.HMASTLOCK = sel ? m1.HMASTLOCK : m0.HMASTLOCK;
  assign s.HWDATA    = data_owner ? m1.HWDATA : m0.HWDATA;

  // address phase accepted: it becomes the next data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_owner <= InitOwner;
      data_owner <= InitOwner;
      data_act   <= 1'b0;
    end else if (s.HREADY) begin
      addr_owner <= sel;
      data_owner <= sel;
      data_act   <= sel_trans[1];
    end
  end

  // responses only reach the master whose data phase is on the slave
  assign m0.HRESP  = (!HRESET && data_act && !data_owner) ? s.HRESP  : RESP_OKAY;
  assign m0.EXRESP = (!HRESET && data_act && !data_owner) ? s.EXRESP : 1'b0;
  assign m1.HRESP  = (!HRESET && data_act &&  data_owner) ? s.HRESP  : RESP_OKAY;
  assign m1.EXRESP = (!HRESET && data_act &&  data_owner) ? s.EXRESP : 1'b0;

  cmsdk_ahb_arb_respbuf u_buf0 (
    .clk       (HCLK),
    .rst       (HRESET),
    .selected  (sel == 1'b0),
    .data_mine (data_act && (data_owner == 1'b0)),
    .hready    (s.HREADY),
    .pending   (trans_pending(m0.HTRANS)),
    .hrdata    (s.HRDATA),
    .hready_m  (m0.HREADY),
    .hrdata_m  (m0.HRDATA)
  );

  cmsdk_ahb_arb_respbuf u_buf1 (
    .clk       (HCLK),
    .rst       (HRESET),
    .selected  (sel == 1'b1),
    .data_mine (data_act && (data_owner == 1'b1)),
    .hready    (s.HREADY),
    .pending   (trans_pending(m1.HTRANS)),
    .hrdata    (s.HRDATA),
    .hready_m  (m1.HREADY),
    .hrdata_m  (m1.HRDATA)
  );

endmodule

// File: tb/tb_cmsdk_ahb_master_arbiter64.sv
// ---------------------------------------------------------------------------
// tb_cmsdk_ahb_master_arbiter64
// Directed cycle-by-cycle bench for the two-master AHB arbiter. Inputs are
// driven 1 time unit after each rising edge, outputs are compared a further
// unit later, against values worked out by hand for each cycle.
// ---------------------------------------------------------------------------
module tb_cmsdk_ahb_master_arbiter64;
  import cmsdk_ahb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESET;
  int   total_checks = 0;
  int   bad_checks   = 0;

  cmsdk_ahb_master_arbiter64_if m0_bus();
  cmsdk_ahb_master_arbiter64_if m1_bus();
  cmsdk_ahb_master_arbiter64_if slv_bus();

  cmsdk_ahb_master_arbiter64 #(.InitOwner(1'b0)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .m0     (m0_bus),
    .m1     (m1_bus),
    .s      (slv_bus)
  );

  // free-running 10-unit clock
  always #5 HCLK = ~HCLK;

  // one comparison: count it, and report it when it disagrees
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // drive one cycle's worth of master requests and slave response, then settle
  task automatic applyStimulus(input logic [1:0] t0, input logic [31:0] a0, input logic l0,
                               input logic [1:0] t1, input logic [31:0] a1, input logic l1,
                               input logic rdy, input logic rsp, input logic [63:0] rdata);
    m0_bus.HTRANS    = t0;
    m0_bus.HADDR     = a0;
    m0_bus.HMASTLOCK = l0;
    m1_bus.HTRANS    = t1;
    m1_bus.HADDR     = a1;
    m1_bus.HMASTLOCK = l1;
    slv_bus.HREADY   = rdy;
    slv_bus.HRESP    = rsp;
    slv_bus.HRDATA   = rdata;
    #1;
  endtask

  // move to just after the next rising edge
  task automatic nextCycle();
    @(posedge HCLK);
    #1;
  endtask

  // default sideband values for both masters and the slave
  task automatic setDefaults();
    m0_bus.HWRITE  = 1'b0;  m1_bus.HWRITE  = 1'b0;
    m0_bus.HSIZE   = 3'd3;  m1_bus.HSIZE   = 3'd3;
    m0_bus.HBURST  = 3'd0;  m1_bus.HBURST  = 3'd0;
    m0_bus.HPROT   = 4'h3;  m1_bus.HPROT   = 4'h3;
    m0_bus.EXREQ   = 1'b0;  m1_bus.EXREQ   = 1'b0;
    m0_bus.MEMATTR = 2'd0;  m1_bus.MEMATTR = 2'd0;
    m0_bus.HWDATA  = '0;    m1_bus.HWDATA  = '0;
    slv_bus.EXRESP = 1'b0;
  endtask

  // one clean reset cycle with both masters idle
  task automatic doReset();
    HRESET = 1'b1;
    setDefaults();
    applyStimulus(TRANS_IDLE, 32'h0, 1'b0, TRANS_IDLE, 32'h0, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    nextCycle();
    HRESET = 1'b0;
  endtask

  // directed scenario sequence
  initial begin
    HRESET = 1'b1;
    setDefaults();

    // reset: responses forced ready/OKAY, slave follows M0 even with M1 requesting
    applyStimulus(TRANS_IDLE, 32'hA0, 1'b0, TRANS_NONSEQ, 32'hB0, 1'b0, 1'b1, RESP_ERROR, 64'h0);
    checkOutput("rst_hready0", m0_bus.HREADY, 1);
    checkOutput("rst_hready1", m1_bus.HREADY, 1);
    checkOutput("rst_hresp1",  m1_bus.HRESP,  0);
    checkOutput("rst_haddr",   slv_bus.HADDR, 32'hA0);
    nextCycle();
    HRESET = 1'b0;

    // single M0 read with one wait state
    applyStimulus(TRANS_NONSEQ, 32'h1000, 1'b0, TRANS_IDLE, 32'h0, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    checkOutput("rd_haddr",   slv_bus.HADDR,  32'h1000);
    checkOutput("rd_htrans",  slv_bus.HTRANS, TRANS_NONSEQ);
    checkOutput("rd_hready0", m0_bus.HREADY,  1);
    nextCycle();
    applyStimulus(TRANS_IDLE, 32'h0, 1'b0, TRANS_IDLE, 32'h0, 1'b0, 1'b0, RESP_OKAY, 64'h0);
    checkOutput("rd_wait_hready0", m0_bus.HREADY, 0);
    nextCycle();
    applyStimulus(TRANS_IDLE, 32'h0, 1'b0, TRANS_IDLE, 32'h0, 1'b0, 1'b1, RESP_OKAY,
                  64'h1122334455667788);
    checkOutput("rd_done_hready0", m0_bus.HREADY, 1);
    checkOutput("rd_hrdata0",      m0_bus.HRDATA, 64'h1122334455667788);
    checkOutput("rd_hresp0",       m0_bus.HRESP,  0);
    checkOutput("rd_hready1_idle", m1_bus.HREADY, 1);
    nextCycle();
    doReset();

    // M0 INCR4 write burst; M1 requests at beat 2 and waits for the burst end
    m0_bus.HWRITE = 1'b1;
    m0_bus.HBURST = 3'b011;
    applyStimulus(TRANS_NONSEQ, 32'h2000, 1'b0, TRANS_IDLE, 32'h3000, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    checkOutput("b1_haddr",  slv_bus.HADDR,  32'h2000);
    checkOutput("b1_hwrite", slv_bus.HWRITE, 1);
    checkOutput("b1_hburst", slv_bus.HBURST, 3'b011);
    nextCycle();
    for (int beat = 1; beat < 4; beat++) begin
      m0_bus.HWDATA = 64'hD0 + 64'(beat - 1);
      applyStimulus(TRANS_SEQ, 32'h2000 + 32'(beat * 4), 1'b0, TRANS_NONSEQ, 32'h3000, 1'b0,
                    1'b1, RESP_OKAY, 64'h0);
      checkOutput($sformatf("b%0d_haddr", beat + 1),   slv_bus.HADDR,  32'h2000 + 32'(beat * 4));
      checkOutput($sformatf("b%0d_hwdata", beat + 1),  slv_bus.HWDATA, 64'hD0 + 64'(beat - 1));
      checkOutput($sformatf("b%0d_hready1", beat + 1), m1_bus.HREADY,  0);
      checkOutput($sformatf("b%0d_hready0", beat + 1), m0_bus.HREADY,  1);
      nextCycle();
    end
    m0_bus.HWDATA = 64'hD3;
    applyStimulus(TRANS_IDLE, 32'h0, 1'b0, TRANS_NONSEQ, 32'h3000, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    checkOutput("sw_haddr",   slv_bus.HADDR,  32'h3000);
    checkOutput("sw_hwrite",  slv_bus.HWRITE, 0);
    checkOutput("sw_hwdata",  slv_bus.HWDATA, 64'hD3);
    checkOutput("sw_hready1", m1_bus.HREADY,  1);
    checkOutput("sw_hready0", m0_bus.HREADY,  0);
    nextCycle();
    applyStimulus(TRANS_IDLE, 32'h0, 1'b0, TRANS_IDLE, 32'h0, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    checkOutput("sw_bufv0",        dut.u_buf0.bufv, 1);
    checkOutput("sw_parked_ready0", m0_bus.HREADY,  0);
    nextCycle();
    doReset();

    // locked M0 pair of transfers holds off a requesting M1
    applyStimulus(TRANS_NONSEQ, 32'h6000, 1'b1, TRANS_NONSEQ, 32'h7000, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    checkOutput("lk1_haddr",   slv_bus.HADDR,     32'h6000);
    checkOutput("lk1_lock",    slv_bus.HMASTLOCK, 1);
    checkOutput("lk1_hready1", m1_bus.HREADY,     0);
    nextCycle();
    applyStimulus(TRANS_NONSEQ, 32'h6004, 1'b1, TRANS_NONSEQ, 32'h7000, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    checkOutput("lk2_haddr",   slv_bus.HADDR, 32'h6004);
    checkOutput("lk2_hready1", m1_bus.HREADY, 0);
    nextCycle();
    applyStimulus(TRANS_IDLE, 32'h0, 1'b0, TRANS_NONSEQ, 32'h7000, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    checkOutput("lk3_haddr",   slv_bus.HADDR,     32'h7000);
    checkOutput("lk3_lock",    slv_bus.HMASTLOCK, 0);
    checkOutput("lk3_hready1", m1_bus.HREADY,     1);
    checkOutput("lk3_hready0", m0_bus.HREADY,     0);
    nextCycle();

    // reset while M1 owns: slave must follow M0 combinationally
    HRESET = 1'b1;
    applyStimulus(TRANS_IDLE, 32'hA000, 1'b0, TRANS_NONSEQ, 32'hB000, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    checkOutput("rst2_haddr",   slv_bus.HADDR, 32'hA000);
    checkOutput("rst2_hready0", m0_bus.HREADY, 1);
    checkOutput("rst2_hready1", m1_bus.HREADY, 1);
    nextCycle();
    HRESET = 1'b0;

    // two-cycle ERROR on an M1 transfer while M0 is requesting
    applyStimulus(TRANS_IDLE, 32'h0, 1'b0, TRANS_NONSEQ, 32'h8000, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    checkOutput("er0_haddr",   slv_bus.HADDR, 32'h8000);
    checkOutput("er0_hready1", m1_bus.HREADY, 1);
    nextCycle();
    applyStimulus(TRANS_NONSEQ, 32'h9000, 1'b0, TRANS_IDLE, 32'h8004, 1'b0, 1'b0, RESP_ERROR, 64'h0);
    checkOutput("er1_haddr",   slv_bus.HADDR, 32'h8004);
    checkOutput("er1_hresp1",  m1_bus.HRESP,  1);
    checkOutput("er1_hready1", m1_bus.HREADY, 0);
    checkOutput("er1_hresp0",  m0_bus.HRESP,  0);
    checkOutput("er1_hready0", m0_bus.HREADY, 0);
    nextCycle();
    applyStimulus(TRANS_NONSEQ, 32'h9000, 1'b0, TRANS_IDLE, 32'h8004, 1'b0, 1'b1, RESP_ERROR, 64'h0);
    checkOutput("er2_haddr",   slv_bus.HADDR, 32'h8004);
    checkOutput("er2_hresp1",  m1_bus.HRESP,  1);
    checkOutput("er2_hready1", m1_bus.HREADY, 1);
    checkOutput("er2_hready0", m0_bus.HREADY, 0);
    nextCycle();
    applyStimulus(TRANS_NONSEQ, 32'h9000, 1'b0, TRANS_IDLE, 32'h0, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    checkOutput("er3_haddr",   slv_bus.HADDR, 32'h9000);
    checkOutput("er3_hready0", m0_bus.HREADY, 1);
    checkOutput("er3_hresp1",  m1_bus.HRESP,  0);
    nextCycle();
    doReset();

    // back-to-back reads from both masters alternate, data comes via buffers
    applyStimulus(TRANS_NONSEQ, 32'h4000, 1'b0, TRANS_IDLE, 32'h0, 1'b0, 1'b1, RESP_OKAY, 64'h0);
    checkOutput("rr1_haddr", slv_bus.HADDR, 32'h4000);
    nextCycle();
    applyStimulus(TRANS_NONSEQ, 32'h4004, 1'b0, TRANS_NONSEQ, 32'h5000, 1'b0, 1'b1, RESP_OKAY,
                  64'hAAAA000000000001);
    checkOutput("rr2_haddr",   slv_bus.HADDR, 32'h5000);
    checkOutput("rr2_hready1", m1_bus.HREADY, 1);
    checkOutput("rr2_hready0", m0_bus.HREADY, 0);
    nextCycle();
    applyStimulus(TRANS_NONSEQ, 32'h4004, 1'b0, TRANS_NONSEQ, 32'h5004, 1'b0, 1'b1, RESP_OKAY,
                  64'hBBBB000000000002);
    checkOutput("rr3_bufv0",   dut.u_buf0.bufv, 1);
    checkOutput("rr3_haddr",   slv_bus.HADDR,   32'h4004);
    checkOutput("rr3_hready0", m0_bus.HREADY,   1);
    checkOutput("rr3_hrdata0", m0_bus.HRDATA,   64'hAAAA000000000001);
    checkOutput("rr3_hready1", m1_bus.HREADY,   0);
    nextCycle();
    applyStimulus(TRANS_IDLE, 32'h0, 1'b0, TRANS_NONSEQ, 32'h5004, 1'b0, 1'b1, RESP_OKAY,
                  64'hAAAA000000000003);
    checkOutput("rr4_bufv0",   dut.u_buf0.bufv, 0);
    checkOutput("rr4_bufv1",   dut.u_buf1.bufv, 1);
    checkOutput("rr4_haddr",   slv_bus.HADDR,   32'h5004);
    checkOutput("rr4_hready1", m1_bus.HREADY,   1);
    checkOutput("rr4_hrdata1", m1_bus.HRDATA,   64'hBBBB000000000002);
    checkOutput("rr4_hready0", m0_bus.HREADY,   0);
    nextCycle();
    applyStimulus(TRANS_NONSEQ, 32'h4008, 1'b0, TRANS_IDLE, 32'h0, 1'b0, 1'b1, RESP_OKAY,
                  64'hBBBB000000000004);
    checkOutput("rr5_bufv1",   dut.u_buf1.bufv, 0);
    checkOutput("rr5_haddr",   slv_bus.HADDR,   32'h4008);
    checkOutput("rr5_hready0", m0_bus.HREADY,   1);
    checkOutput("rr5_hrdata0", m0_bus.HRDATA,   64'hAAAA000000000003);
    checkOutput("rr5_hready1", m1_bus.HREADY,   0);
    nextCycle();

    // reset with M1 data parked: buffer is dropped, owner back to M0
    HRESET = 1'b1;
    applyStimulus(TRANS_IDLE, 32'h0, 1'b0, TRANS_IDLE, 32'h0, 1'b0, 1'b1, RESP_ERROR,
                  64'h5555666677778888);
    checkOutput("rst3_bufv1_before", dut.u_buf1.bufv, 1);
    checkOutput("rst3_hready0",      m0_bus.HREADY,   1);
    checkOutput("rst3_hready1",      m1_bus.HREADY,   1);
    checkOutput("rst3_hresp0",       m0_bus.HRESP,    0);
    nextCycle();
    HRESET = 1'b0;
    applyStimulus(TRANS_IDLE, 32'h0, 1'b0, TRANS_IDLE, 32'h0, 1'b0, 1'b1, RESP_OKAY,
                  64'h5555666677778888);
    checkOutput("rst3_bufv1_after", dut.u_buf1.bufv,  0);
    checkOutput("rst3_owner",       dut.addr_owner,   0);
    checkOutput("rst3_hrdata1",     m1_bus.HRDATA,    64'h5555666677778888);
    checkOutput("rst3_hready1_idle", m1_bus.HREADY,   1);
    nextCycle();

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/cmsdk_ahb_master_arbiter64.md
CMSDK_AHB_MASTER_ARBITER64 -- requirements
Module: cmsdk_ahb_master_arbiter64

Interface
REQ-001 Parameter InitOwner, default 0: address-phase owner after reset (0 = M0, 1 = M1).
REQ-002 The block SHALL use one clock. Reset is synchronous and active-high.
REQ-003 HCLK  in  1  system clock.
REQ-004 HRESET  in  1  synchronous active-high reset.
REQ-005 HTRANSM0/M1  in  2 each  master transfer type.
REQ-006 HADDRM0/M1 in 32, HWRITEM0/M1 in 1, HSIZEM0/M1 in 3, HBURSTM0/M1 in 3: master control inputs.
REQ-007 HPROTM0/M1 in 4, EXREQM0/M1 in 1, MEMATTRM0/M1 in 2, HMASTLOCKM0/M1 in 1: master sideband inputs.
REQ-008 HWDATAM0/M1  in  64 each  master write data.
REQ-009 HREADYM0/M1 out 1, HRESPM0/M1 out 1, EXRESPM0/M1 out 1, HRDATAM0/M1 out 64: per-master responses.
REQ-010 HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, EXREQ, MEMATTR, HMASTLOCK, HWDATA  out: slave-side bus, same widths as the master inputs.
REQ-011 HREADY, HRESP, EXRESP, HRDATA[63:0]  in: slave response.

Function
REQ-012 Registers SHALL be: addr_owner; data_owner; data_act; per-master buffer valid bufv0/bufv1; per-master buffer data buf0/buf1[63:0].
REQ-013 sel (combinational) SHALL default to addr_owner.
REQ-014 sel SHALL switch to the other master only when all of the following hold: HREADY=1; HRESP=0; the owner's HMASTLOCK=0; the owner's HTRANS is IDLE or NONSEQ; the other master's HTRANS=NONSEQ.
REQ-015 When both masters present NONSEQ, sel SHALL pass to the non-owner (round-robin at transfer granularity). SEQ/BUSY beats SHALL never lose the bus.
REQ-016 Slave address/control outputs SHALL be muxed from sel with zero latency. HWDATA SHALL be muxed from data_owner.
REQ-017 On HREADY=1, the block SHALL load: addr_owner<=sel; data_owner<=sel; data_act<=HTRANS[1] of sel.
REQ-018 HRESPM/EXRESPM of master i SHALL equal HRESP/EXRESP when data_act=1 and data_owner=i, else 0.
REQ-019 Owner losing the bus in the same cycle as its data phase completes (data_owner=i, data_act=1, sel!=i, HREADY=1): HREADYMi SHALL be 0; HRDATA SHALL be captured into bufi; bufvi SHALL be set.
REQ-020 Master i with sel=i: HREADYMi SHALL equal HREADY. HRDATAMi SHALL be bufi when bufvi=1, else HRDATA. bufvi SHALL clear on HREADY=1.
REQ-021 Master i with sel!=i: HREADYMi SHALL be 0 when its HTRANS is NONSEQ/SEQ or bufvi=1, else 1. The non-owner data phase in REQ-019 takes precedence.
REQ-022 An ERROR response (HRESP=1) SHALL suppress switching in both of its cycles; the buffers therefore hold OKAY data only.
REQ-023 Neither master active: the slave SHALL see the parked owner's IDLE.
REQ-024 Latency: zero added cycles for the owner. A switched-in master SHALL be accepted in the switch cycle.

Reset
REQ-025 When HRESET=1 at a HCLK edge, the block SHALL set: addr_owner=data_owner=InitOwner; data_act=0; bufv0=bufv1=0; buf0=buf1=0.
REQ-026 During reset, HREADYM0/M1 SHALL be 1 and HRESPM/EXRESPM SHALL be 0. Slave outputs SHALL follow the InitOwner master combinationally.
REQ-027 Reset mid-transfer SHALL discard buffered data without completing it.

Structure
REQ-028 HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and HRESP OKAY/ERROR SHALL be defined as constants in shared package cmsdk_ahb_pkg.
REQ-029 The per-master response buffer (REQ-019/020) SHALL be one sub-module, cmsdk_ahb_arb_respbuf, instantiated twice.

Verification
REQ-030 Reset, M0 single read 0x1000 with HRDATA=0x1122334455667788 -> HREADYM0 mirrors HREADY; HRDATAM0=0x1122334455667788; M1 idle sees HREADYM1=1.
REQ-031 M0 INCR4 writes while M1 issues NONSEQ at beat 2 -> all 4 M0 beats on the bus; M1 stalled (HREADYM1=0) until M0 next IDLE/NONSEQ; M1 granted in that cycle.
REQ-032 Both issue back-to-back NONSEQ reads -> bus alternates M0,M1,M0,M1. Each master's data is delivered from its buffer (bufv set then cleared) with the correct value.
REQ-033 M0 HMASTLOCK=1 across two NONSEQ transfers, M1 requesting -> no switch until M0 deasserts lock.
REQ-034 Slave two-cycle ERROR on M1 transfer while M0 requesting -> HRESPM1=1 for both cycles; no switch during them; M0 granted afterwards.
REQ-035 HRESET asserted with bufv1=1 -> bufv1=0 next cycle; addr_owner=InitOwner; HREADYM0/M1=1.
